regfile_wb_writer: RTL and testbench

- Write side of the pipeline's 32x32 general-purpose register file.
- Accepts one write-back request per cycle from the WB stage and holds all 32 registers.
- Presents the registers as a flat bus to the read-side 32:1 selectors.
- Keeps a per-register pending scoreboard: the ID stage marks a destination busy at issue, and write-back clears it.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_wdec.sv | 23 ++
 rtl/regfile_wb_writer.sv | 117 +++++++++++
 tb/tb_regfile_wb_writer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and types for the GPR write side.
//   REG_DW   : register data width
//   REG_NUM  : number of architectural registers
//   REG_AW   : register address width
//   REG_ZERO : address of the hardwired-zero register
// Optional build macro used by regfile_wb_writer: REGFILE_WB_BYPASS_EN
package regfile_pkg;

  localparam int REG_DW  = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wdec.sv
// regfile_wdec -- 5-to-32 enable decoder for register-file writes.
// Ports:
//   en  : decode enable; all outputs low when 0
//   sel : register address to decode
//   we  : one-hot enable vector; bit 0 is always 0 (register 0 is hardwired)
module regfile_wdec
  import regfile_pkg::*;
(
  input  logic              en,
  input  reg_addr_t         sel,
  output logic [REG_NUM-1:0] we
);

  // Register 0 never takes a write or a pending mark.
  assign we[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_dec
      assign we[gi] = en && (sel == REG_AW'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer -- write side of the 32x32 general-purpose register file.
// Holds all registers, accepts one write-back per cycle and tracks a
// per-register pending scoreboard (set at issue, cleared at write-back).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wb_valid/wb_ready   : write-back handshake (wb_ready=1 from the first
//                         edge after reset release onwards)
//   wb_sel, wb_data     : write-back destination and data
//   iss_en, iss_sel     : ID-stage issue of a destination register
//   regs_flat           : register k at bits [k*DW +: DW]; register 0 reads 0
//   pending             : bit k = register k awaits write-back
//   wb_err              : sticky, write-back to a register that was not pending
// Build option: define REGFILE_WB_BYPASS_EN to make regs_flat write-through
// (an accepted write shows on its slice in the same cycle).
module regfile_wb_writer
  import regfile_pkg::*;
#(
  parameter int DW   = REG_DW,
  parameter int NREG = REG_NUM,
  parameter int AW   = REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [AW-1:0]      wb_sel,
  input  logic [DW-1:0]      wb_data,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_sel,
  output logic [NREG*DW-1:0] regs_flat,
  output logic [NREG-1:0]    pending,
  output logic               wb_err
);

  logic            wb_ready_q, wb_ready_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            wb_err_q, wb_err_d;
  logic [DW-1:0]   regs_q [1:NREG-1];
  logic [DW-1:0]   regs_d [1:NREG-1];

  logic            wb_fire;
  logic [NREG-1:0] wb_we;
  logic [NREG-1:0] iss_set;

  assign wb_fire = wb_valid && wb_ready_q;

  regfile_wdec u_wb_dec (
    .en  (wb_fire),
    .sel (wb_sel),
    .we  (wb_we)
  );

  regfile_wdec u_iss_dec (
    .en  (iss_en),
    .sel (iss_sel),
    .we  (iss_set)
  );

  // Next-state logic for control and scoreboard.
  always_comb begin
    // The writer never stalls; ready comes up one edge after reset release.
    wb_ready_d = 1'b1;
    // Set after clear: a newly issued producer supersedes a same-cycle
    // write-back to the same register. Bit 0 stays 0 via the decoders.
    pending_d  = (pending_q & ~wb_we) | iss_set;
    wb_err_d   = wb_err_q;
    if (wb_fire && (wb_sel != REG_ZERO) && !pending_q[wb_sel]) begin
      wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ready_q <= 1'b0;
      pending_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_ready_q <= wb_ready_d;
      pending_q  <= pending_d;
      wb_err_q   <= wb_err_d;
    end
  end

  // Register storage; register 0 has no storage at all.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      always_comb begin
        regs_d[gi] = wb_we[gi] ? wb_data : regs_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end

`ifdef REGFILE_WB_BYPASS_EN
      // Write-through: the read selectors see accepted data immediately.
      assign regs_flat[gi*DW +: DW] = wb_we[gi] ? wb_data : regs_q[gi];
`else
      assign regs_flat[gi*DW +: DW] = regs_q[gi];
`endif
    end
  endgenerate

  assign regs_flat[DW-1:0] = '0;

  // Output assignments.
  always_comb begin
    wb_ready = wb_ready_q;
    pending  = pending_q;
    wb_err   = wb_err_q;
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// tb_regfile_wb_writer -- directed, table-driven bench for regfile_wb_writer.
// Build option mirrored from the design: REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_writer;

  logic          clk;
  logic          rst_n;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_sel;
  logic [31:0]   wb_data;
  logic          iss_en;
  logic [4:0]    iss_sel;
  logic [1023:0] regs_flat;
  logic [31:0]   pending;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .regs_flat (regs_flat),
    .pending   (pending),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iss_en;
    logic [4:0]  iss_sel;
    logic        wb_valid;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic [4:0]  chk_sel;
    logic [31:0] exp_reg;
    logic [31:0] exp_pend;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  function automatic logic [31:0] reg_word(input int k);
    return regs_flat[k*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0;
    wb_sel   = 5'd0;
    wb_data  = 32'h0;
    iss_en   = 1'b0;
    iss_sel  = 5'd0;
  endtask

  initial begin
    // Step-by-step vectors; expectations are the state after the edge.
    vecs[0] = '{1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        5'd5,  32'h0,        32'h0000_0020, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  32'h0,        32'h0000_0200, 1'b0};
    vecs[3] = '{1'b1, 5'd9,  1'b1, 5'd9,  32'h0000_1234, 5'd9, 32'h0000_1234, 32'h0000_0200, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        32'h0000_0200, 1'b0};
    vecs[5] = '{1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h0000_0200, 1'b0};
    vecs[6] = '{1'b1, 5'd12, 1'b1, 5'd9,  32'h0000_0055, 5'd9, 32'h0000_0055, 32'h0000_1000, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 32'hA5A5A5A5, 32'h0000_1000, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 32'h0000_1000, 1'b1};
    vecs[9] = '{1'b0, 5'd0,  1'b1, 5'd12, 32'h0000_CAFE, 5'd12, 32'h0000_CAFE, 32'h0000_0000, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_regs_or",  64'(|regs_flat), 64'd0);
    chk("rst_pending",  64'(pending),    64'd0);
    chk("rst_err",      64'(wb_err),     64'd0);
    chk("rst_ready",    64'(wb_ready),   64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(wb_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge",  64'(wb_ready), 64'd1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      iss_en   = vecs[i].iss_en;
      iss_sel  = vecs[i].iss_sel;
      wb_valid = vecs[i].wb_valid;
      wb_sel   = vecs[i].wb_sel;
      wb_data  = vecs[i].wb_data;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      chk($sformatf("v%0d_reg%0d", i, vecs[i].chk_sel),
          64'(reg_word(int'(vecs[i].chk_sel))), 64'(vecs[i].exp_reg));
      chk($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pend));
      chk($sformatf("v%0d_err", i),     64'(wb_err),  64'(vecs[i].exp_err));
      chk($sformatf("v%0d_ready", i),   64'(wb_ready), 64'd1);
    end
    chk("reg0_zero", 64'(reg_word(0)), 64'd0);

    // Asynchronous reset mid-cycle with a write in flight.
    @(negedge clk);
    wb_valid = 1'b1;
    wb_sel   = 5'd3;
    wb_data  = 32'h0000_0BAD;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regs_or", 64'(|regs_flat), 64'd0);
    chk("mid_rst_pending", 64'(pending),    64'd0);
    chk("mid_rst_err",     64'(wb_err),     64'd0);
    chk("mid_rst_ready",   64'(wb_ready),   64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_reg3", 64'(reg_word(3)), 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerelease_ready", 64'(wb_ready), 64'd1);
    chk("rerelease_err",   64'(wb_err),   64'd0);

    // Same-cycle visibility of a write: write-through vs registered.
    @(negedge clk);
    wb_valid = 1'b1;
    wb_sel   = 5'd3;
    wb_data  = 32'd7;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("same_cycle_reg3", 64'(reg_word(3)), 64'd7);
`else
    chk("same_cycle_reg3", 64'(reg_word(3)), 64'd0);
`endif
    chk("same_cycle_reg0", 64'(reg_word(0)), 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("post_edge_reg3", 64'(reg_word(3)), 64'd7);
    chk("post_edge_err",  64'(wb_err),      64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
